oldest_first_arbiter: RTL and testbench

OLDEST_FIRST_ARBITER -- requirements
Module: oldest_first_arbiter

---
 rtl/mesh_arb_pkg.sv | 33 +++
 rtl/oldest_select.sv | 60 ++++++
 rtl/oldest_first_arbiter.sv | 155 +++++++++++++++
 tb/tb_oldest_first_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mesh_arb_pkg.sv
// -----------------------------------------------------------------------------
// mesh_arb_pkg
// Shared definitions for the mesh router output-port arbiter:
//   - default parameter values (requester count, timestamp width, hold limit)
//   - arb_state_t FSM encoding
//   - port-index constants for the five mesh directions
//   - ptr_w(): pointer width helper that stays >= 1 for a single requester
// -----------------------------------------------------------------------------
package mesh_arb_pkg;

  localparam int N_REQ_DEF    = 5;
  localparam int TS_W_DEF     = 8;
  localparam int MAX_HOLD_DEF = 64;

  // Requester index assignment on a 5-port mesh router.
  localparam int PORT_N     = 0;
  localparam int PORT_E     = 1;
  localparam int PORT_S     = 2;
  localparam int PORT_W     = 3;
  localparam int PORT_LOCAL = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Width of an index into n entries; never zero so a 1-port build still
  // has a legal vector declaration.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/oldest_select.sv
// -----------------------------------------------------------------------------
// oldest_select
// Combinational winner selection: among active requesters, pick the one with
// the smallest (unsigned) timestamp. Equal timestamps are resolved by scanning
// upward from rr_ptr with wrap-around.
// Ports:
//   req     in  N_REQ        active request per port
//   ts      in  N_REQ*TS_W   packed timestamps, port i at [i*TS_W +: TS_W]
//   rr_ptr  in  PTR_W        round-robin start index for tie resolution
//   winner  out N_REQ        one-hot winner, zero when req == 0
// -----------------------------------------------------------------------------
module oldest_select
  import mesh_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int TS_W  = TS_W_DEF,
  parameter int PTR_W = ptr_w(N_REQ_DEF)
) (
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*TS_W-1:0] ts,
  input  logic [PTR_W-1:0]      rr_ptr,
  output logic [N_REQ-1:0]      winner
);

  logic [TS_W-1:0]  min_ts;
  logic [N_REQ-1:0] tied;
  logic             found;
  int               idx;

  // Smallest timestamp among active requesters. Starting at all-ones is safe:
  // a requester whose timestamp is all-ones still matches in the tie vector.
  always_comb begin
    min_ts = '1;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i] && (ts[i*TS_W +: TS_W] < min_ts)) begin
        min_ts = ts[i*TS_W +: TS_W];
      end
    end
  end

  // Every active requester holding the minimum timestamp is a candidate.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_tied
    assign tied[gi] = req[gi] && (ts[gi*TS_W +: TS_W] == min_ts);
  end

  // First candidate at or after rr_ptr, wrapping past the top index.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && tied[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/oldest_first_arbiter.sv
// -----------------------------------------------------------------------------
// oldest_first_arbiter
// Packet-granular arbiter for one mesh output port. In IDLE it grants the
// oldest requester (smallest timestamp, round-robin on ties) and locks onto
// it until the packet's tail flit transfers, the holder drops its request,
// or the grant has been held MAX_HOLD cycles (forced release with a one-cycle
// timeout pulse). Every release returns to IDLE, giving one bubble cycle.
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high reset
//   req          in   N_REQ       head flit present per port
//   ts           in   N_REQ*TS_W  head-packet timestamp per port (lower = older)
//   tail         in   N_REQ       head flit is the last of its packet
//   ready_out    in   downstream accepts a flit this cycle
//   grant        out  N_REQ       registered one-hot (or zero) grant
//   grant_valid  out  registered |grant
//   timeout      out  registered one-cycle pulse on forced release
// -----------------------------------------------------------------------------
module oldest_first_arbiter
  import mesh_arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int TS_W     = TS_W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*TS_W-1:0] ts,
  input  logic [N_REQ-1:0]      tail,
  input  logic                  ready_out,
  output logic [N_REQ-1:0]      grant,
  output logic                  grant_valid,
  output logic                  timeout
);

  localparam int PTR_W  = ptr_w(N_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t        state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              grant_valid_q;
  logic              timeout_q, timeout_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [N_REQ-1:0]  winner;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  ptr_after_grant;
  logic              holder_req;
  logic              holder_tail;
  logic              transfer;
  logic              tail_release;
  logic              abort_release;
  logic              normal_release;
  logic              expire;

  oldest_select #(
    .N_REQ (N_REQ),
    .TS_W  (TS_W),
    .PTR_W (PTR_W)
  ) u_select (
    .req    (req),
    .ts     (ts),
    .rr_ptr (rr_ptr_q),
    .winner (winner)
  );

  // Index of the current holder (grant_q is one-hot while LOCKED).
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        grant_idx = PTR_W'(i);
      end
    end
  end

  // Round-robin start moves to the port just after the releasing holder.
  always_comb begin
    if (int'(grant_idx) == N_REQ - 1) begin
      ptr_after_grant = '0;
    end else begin
      ptr_after_grant = grant_idx + PTR_W'(1);
    end
  end

  assign holder_req     = |(req & grant_q);
  assign holder_tail    = |(tail & grant_q);
  assign transfer       = holder_req & ready_out;
  assign tail_release   = transfer & holder_tail;
  assign abort_release  = ~holder_req;
  assign normal_release = tail_release | abort_release;
  // A normal release in the expiry cycle wins, so timeout stays low then.
  assign expire         = (hold_cnt_q == HOLD_LAST) & ~normal_release;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d    = '0;
        hold_cnt_d = '0;
        if (|req) begin
          grant_d = winner;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (normal_release || expire) begin
          grant_d    = '0;
          state_d    = IDLE;
          rr_ptr_d   = ptr_after_grant;
          hold_cnt_d = '0;
          timeout_d  = expire;
        end else begin
          // Counts regardless of ready_out: backpressure uses up the budget.
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        grant_d    = '0;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      rr_ptr_q      <= '0;
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= |grant_d;
      timeout_q     <= timeout_d;
      rr_ptr_q      <= rr_ptr_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_oldest_first_arbiter.sv
// -----------------------------------------------------------------------------
// tb_oldest_first_arbiter
// Directed bench for oldest_first_arbiter (N_REQ=5, TS_W=8, MAX_HOLD=4).
// Inputs change 1 ns after a rising edge; outputs are checked at that same
// point, i.e. reflecting the edge just taken.
// -----------------------------------------------------------------------------
module tb_oldest_first_arbiter;

  localparam int N        = 5;
  localparam int TW       = 8;
  localparam int MAX_HOLD = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*TW-1:0] ts;
  logic [N-1:0]    tail;
  logic            ready_out;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic            timeout;

  int n_cmp = 0;
  int n_err = 0;

  oldest_first_arbiter #(
    .N_REQ    (N),
    .TS_W     (TW),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .ts          (ts),
    .tail        (tail),
    .ready_out   (ready_out),
    .grant       (grant),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ts(input int idx, input logic [TW-1:0] val);
    ts[idx*TW +: TW] = val;
  endtask

  task automatic check(input string tag, input logic [N-1:0] exp_g, input logic exp_to);
    logic exp_gv;
    exp_gv = |exp_g;
    n_cmp++;
    assert (grant === exp_g) else begin
      n_err++;
      $error("FAIL %s grant observed=%b expected=%b", tag, grant, exp_g);
    end
    n_cmp++;
    assert (grant_valid === exp_gv) else begin
      n_err++;
      $error("FAIL %s grant_valid observed=%b expected=%b", tag, grant_valid, exp_gv);
    end
    n_cmp++;
    assert (timeout === exp_to) else begin
      n_err++;
      $error("FAIL %s timeout observed=%b expected=%b", tag, timeout, exp_to);
    end
    $display("step %-14s grant=%b gv=%b to=%b", tag, grant, grant_valid, timeout);
  endtask

  initial begin
    reset     = 1'b1;
    req       = '0;
    ts        = '0;
    tail      = '0;
    ready_out = 1'b0;
    step();
    check("reset", 5'b00000, 1'b0);
    reset = 1'b0;

    // Single request on port 2; granted one edge later, released on tail.
    req = 5'b00100; set_ts(2, 8'd5); ready_out = 1'b1;
    step();
    check("single_grant", 5'b00100, 1'b0);
    tail = 5'b00100;
    step();
    check("single_tail", 5'b00000, 1'b0);  // rr_ptr -> 3
    req = '0; tail = '0;
    step();
    check("idle_hold", 5'b00000, 1'b0);

    // Move rr_ptr to 2 via a one-flit packet on port 1.
    req = 5'b00010; set_ts(1, 8'd0); tail = 5'b00010;
    step();
    check("p1_grant", 5'b00010, 1'b0);
    step();
    check("p1_tail", 5'b00000, 1'b0);      // rr_ptr -> 2

    // Oldest wins: ts {9,3,7,3,12}, tie 1/3 from ptr 2 -> port 3.
    req = 5'b11111; tail = '0; ready_out = 1'b0;
    set_ts(0, 8'd9); set_ts(1, 8'd3); set_ts(2, 8'd7); set_ts(3, 8'd3); set_ts(4, 8'd12);
    step();
    check("oldest_p3", 5'b01000, 1'b0);
    // Locked: older timestamps elsewhere are ignored.
    set_ts(0, 8'd0); set_ts(4, 8'd0);
    step();
    check("locked_hold", 5'b01000, 1'b0);
    // Abort: holder drops request.
    req = 5'b10111;
    step();
    check("abort", 5'b00000, 1'b0);        // rr_ptr -> 4
    // Ports 0 and 4 tie at ts 0; from ptr 4 port 4 wins.
    step();
    check("tie_from_4", 5'b10000, 1'b0);
    // Reset mid-packet drops everything on that edge.
    reset = 1'b1;
    step();
    check("reset_locked", 5'b00000, 1'b0);
    reset = 1'b0; req = '0;
    step();
    check("post_reset", 5'b00000, 1'b0);

    // Tie rotation: ports 0/1 both ts 4, single-flit packets, rr_ptr 0.
    req = 5'b00011; set_ts(0, 8'd4); set_ts(1, 8'd4); tail = 5'b00011; ready_out = 1'b1;
    step();
    check("rot_p0", 5'b00001, 1'b0);
    step();
    check("rot_gap1", 5'b00000, 1'b0);
    step();
    check("rot_p1", 5'b00010, 1'b0);
    step();
    check("rot_gap2", 5'b00000, 1'b0);
    step();
    check("rot_p0b", 5'b00001, 1'b0);
    req = '0;
    step();
    check("rot_gap3", 5'b00000, 1'b0);     // abort/tail release, rr_ptr -> 1

    // Timeout under backpressure: no tail, ready_out low, MAX_HOLD 4.
    req = 5'b00100; set_ts(2, 8'd1); tail = '0; ready_out = 1'b0;
    step();
    check("to_grant", 5'b00100, 1'b0);
    step();
    check("to_hold1", 5'b00100, 1'b0);
    step();
    check("to_hold2", 5'b00100, 1'b0);
    step();
    check("to_hold3", 5'b00100, 1'b0);
    step();
    check("to_expire", 5'b00000, 1'b1);
    req = '0;
    step();
    check("to_pulse_end", 5'b00000, 1'b0);

    // Tail transfer in the expiry cycle is a normal release.
    req = 5'b00001; set_ts(0, 8'd2);
    step();
    check("tx_grant", 5'b00001, 1'b0);
    step();
    check("tx_hold1", 5'b00001, 1'b0);
    step();
    check("tx_hold2", 5'b00001, 1'b0);
    step();
    check("tx_hold3", 5'b00001, 1'b0);
    tail = 5'b00001; ready_out = 1'b1;
    step();
    check("tx_tail_exp", 5'b00000, 1'b0);
    req = '0; tail = '0;
    step();
    check("final_idle", 5'b00000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
